// File: rtl/fp_pkg.sv
// Shared floating-point constants, status encodings and FSM state type
// for the MyALU float_mul / float_div units.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [1:0] YC_OK  = 2'b00;
  localparam logic [1:0] YC_OVF = 2'b01;
  localparam logic [1:0] YC_UNF = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM,
    ST_DONE
  } fsm_state_t;

  typedef struct packed {
    logic [1:0]  yc;
    logic [31:0] z;
  } fp_res_t;

endpackage

// File: rtl/mant_mul_seq.sv
// Sequential shift-add mantissa multiplier: one multiplier bit per clock,
// W cycles after load, then a one-cycle valid pulse with the 2W-bit product.
module mant_mul_seq
  import fp_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           valid,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             valid_q, valid_d;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    valid_d = 1'b0;
    if (load) begin
      a_d    = a;
      b_d    = b;
      prod_d = '0;
      cnt_d  = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (b_q[cnt_q]) begin
        prod_d = prod_q + ({{W{1'b0}}, a_q} << cnt_q);
      end
      if (cnt_q == CNT_W'(W - 1)) begin
        run_d   = 1'b0;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign valid   = valid_q;
  assign product = prod_q;

endmodule

// File: rtl/float_mul.sv
// Multi-cycle IEEE-754 single-precision multiplier with start/done handshake.
// Unpacks operands, runs the sequential mantissa multiplier, then normalizes and packs.
module float_mul
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ix,
  input  logic [31:0] iy,
  output logic [31:0] oz,
  output logic [1:0]  Yichu,
  output logic        busy,
  output logic        done
);

  localparam int PW = 2 * MANT_W;
  localparam int FW = MANT_W - 1;
  localparam logic signed [9:0] E_BIAS = 10'(BIAS);
  localparam logic signed [9:0] E_SAT  = 10'(EXP_MAX);

  fsm_state_t       state_q;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             inf_q, inf_d;
  logic [EXP_W-1:0] ex_q, ex_d;
  logic [EXP_W-1:0] ey_q, ey_d;
  logic [31:0]      oz_q;
  logic [1:0]       yichu_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             mul_valid;
  logic [PW-1:0]    prod;
  logic signed [9:0] e_norm;
  logic [FW-1:0]    mant_norm;
  fp_res_t          res;
  logic             unused_prod_lsbs;

  assign accept = (state_q == ST_IDLE) && start;

  mant_mul_seq #(.W(MANT_W)) u_mant (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .a       ({1'b1, ix[FW-1:0]}),
    .b       ({1'b1, iy[FW-1:0]}),
    .valid   (mul_valid),
    .product (prod)
  );

  // Zero wins over Inf; NaN is folded into Inf, denormals into zero.
  function automatic fp_res_t pack_result(input logic s, input logic z, input logic inf,
                                          input logic signed [9:0] e,
                                          input logic [FW-1:0] m);
    fp_res_t r;
    if (z) begin
      r.yc = YC_OK;
      r.z  = {s, 31'b0};
    end else if (inf || (e >= E_SAT)) begin
      r.yc = YC_OVF;
      r.z  = {s, 8'hFF, 23'b0};
    end else if (e <= 10'sd0) begin
      r.yc = YC_UNF;
      r.z  = {s, 31'b0};
    end else begin
      r.yc = YC_OK;
      r.z  = {s, e[EXP_W-1:0], m};
    end
    return r;
  endfunction

  always_comb begin
    sign_d = sign_q;
    zero_d = zero_q;
    inf_d  = inf_q;
    ex_d   = ex_q;
    ey_d   = ey_q;
    if (accept) begin
      sign_d = ix[31] ^ iy[31];
      ex_d   = ix[30:23];
      ey_d   = iy[30:23];
      zero_d = (ix[30:23] == '0) || (iy[30:23] == '0);
      inf_d  = (ix[30:23] == EXP_W'(EXP_MAX)) || (iy[30:23] == EXP_W'(EXP_MAX));
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    zero_q <= zero_d;
    inf_q  <= inf_d;
    ex_q   <= ex_d;
    ey_q   <= ey_d;
  end

  // Normalize: product of two [1,2) mantissas lies in [1,4); truncating round.
  always_comb begin
    e_norm = $signed({2'b00, ex_q}) + $signed({2'b00, ey_q}) - E_BIAS;
    if (prod[PW-1]) begin
      e_norm    = e_norm + 10'sd1;
      mant_norm = prod[PW-2 -: FW];
    end else begin
      mant_norm = prod[PW-3 -: FW];
    end
    res = pack_result(sign_q, zero_q, inf_q, e_norm, mant_norm);
  end

  assign unused_prod_lsbs = ^prod[PW-MANT_W-2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      oz_q    <= '0;
      yichu_q <= YC_OK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mul_valid) state_q <= ST_NORM;
        end
        ST_NORM: begin
          oz_q    <= res.z;
          yichu_q <= res.yc;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign oz    = oz_q;
  assign Yichu = yichu_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_float_mul.sv
// Directed-vector bench for float_mul: an arithmetic reference model feeds a
// scoreboard queue checked every cycle, plus hand-computed literal results.
module tb_float_mul;

  logic        clk, rst, start;
  logic [31:0] ix, iy, oz;
  logic [1:0]  Yichu;
  logic        busy, done;

  float_mul dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ix    (ix),
    .iy    (iy),
    .oz    (oz),
    .Yichu (Yichu),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    logic [31:0] z;
    logic [1:0]  yc;
    int          c;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_ok = 0;
  logic [31:0] held_z = '0;
  logic [1:0]  held_yc = '0;

  logic [31:0] vx  [0:10] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h7F000000,
                              32'h7F800000, 32'h00800000, 32'h00000000, 32'h00000000,
                              32'hFF000000, 32'h7FC00000, 32'h3FFFFFFF};
  logic [31:0] vy  [0:10] = '{32'h40400000, 32'h3FC00000, 32'h3F000000, 32'h7F000000,
                              32'h3F800000, 32'h00800000, 32'h40400000, 32'h7F800000,
                              32'h7F000000, 32'h40000000, 32'h3FFFFFFF};
  logic [31:0] vz  [0:10] = '{32'h40C00000, 32'h40100000, 32'hBF800000, 32'h7F800000,
                              32'h7F800000, 32'h00000000, 32'h00000000, 32'h00000000,
                              32'hFF800000, 32'h7F800000, 32'h407FFFFE};
  logic [1:0]  vyc [0:10] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00,
                              2'b01, 2'b01, 2'b00};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product of the significands, then IEEE field rules.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    logic        s;
    logic [63:0] p;
    logic [22:0] m;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if (ex == 0 || ey == 0) return {2'b00, s, 31'b0};
    if (ex == 255 || ey == 255) return {2'b01, s, 8'hFF, 23'b0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin
      e = e + 1;
      m = 23'(p >> 24);
    end else begin
      m = 23'(p >> 23);
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'b0};
    if (e <= 0) return {2'b10, s, 31'b0};
    return {2'b00, s, 8'(e), m};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=oz %h expected=no done (t=%0t)", oz, $time);
        end else begin
          mon_e = q.pop_front();
          chk("oz", oz, mon_e.z);
          chk("yichu", 32'(Yichu), 32'(mon_e.yc));
          chk("latency", 32'(cyc - mon_e.c), 32'd26);
          chk("busy_at_done", 32'(busy), 32'd0);
          held_z  = mon_e.z;
          held_yc = mon_e.yc;
        end
      end else begin
        chk("oz_hold", oz, held_z);
        chk("yichu_hold", 32'(Yichu), 32'(held_yc));
        chk("busy", 32'(busy), 32'(q.size() != 0));
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    logic [33:0] m;
    @(negedge clk);
    ix = x;
    iy = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    m = model(x, y);
    q.push_back('{z: m[31:0], yc: m[33:32], c: cyc});
    n_ok++;
    start = 1'b0;
    ix = $urandom;
    iy = $urandom;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no done expected=done within 40 cycles", name);
    end
  endtask

  task automatic run_lit(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ez, input logic [1:0] eyc);
    issue(x, y);
    wait_done(name);
    #1;
    chk({name, "_oz"}, oz, ez);
    chk({name, "_yc"}, 32'(Yichu), 32'(eyc));
  endtask

  initial begin
    int d0;
    logic [31:0] rx, ry;
    rst = 1'b1;
    start = 1'b0;
    ix = '0;
    iy = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oz", oz, 32'h0);
    chk("rst_yc", 32'(Yichu), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Directed vectors issued back-to-back: each start follows the previous done.
    for (int i = 0; i <= 10; i++) begin
      run_lit($sformatf("vec%0d", i), vx[i], vy[i], vz[i], vyc[i]);
    end

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = $urandom;
      rx[30:23] = 8'($urandom_range(60, 190));
      ry[30:23] = 8'($urandom_range(60, 190));
      issue(rx, ry);
      wait_done($sformatf("rnd%0d", i));
    end

    // A start pulse while busy must be ignored.
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    issue(32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    ix = 32'h3FC00000;
    iy = 32'h3FC00000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_ign");
    #1;
    chk("busy_ign_oz", oz, 32'h40C00000);
    repeat (35) @(negedge clk);
    chk("busy_ign_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Abort mid-multiply with reset.
    issue(32'h3FC00000, 32'h40000000);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_oz", oz, 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_yc", 32'(Yichu), 32'h0);
    q.delete();
    n_ok--;
    held_z = '0;
    held_yc = '0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run_lit("after_abort", 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00);
    repeat (3) @(negedge clk);
    chk("total_done", 32'(done_cnt), 32'(n_ok));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
